// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial sequence detector.
//   - state_e: controller FSM state encoding
//   - MAXLEN_DEFAULT / CNTW_DEFAULT: default pattern length and counter width
package seq_pkg;

    localparam int unsigned MAXLEN_DEFAULT = 8;
    localparam int unsigned CNTW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, fill counter and pattern compare.
// Ports:
//   clk, Reset   - clock, asynchronous active-low reset
//   clear        - wipe history and fill (start of a run)
//   accept       - w is consumed this cycle
//   w            - serial data bit
//   pat, len     - latched pattern and length (len > MAXLEN is clamped, len 0 never matches)
//   match        - combinational: the bit being accepted completes a match
// Build option: SEQ_DETECT_OVERLAP_EN keeps fill across a match so matches may overlap;
// without it fill restarts at 0 after every match.
module seq_match_core
    import seq_pkg::*;
#(
    parameter int unsigned MAXLEN = MAXLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              w,
    input  logic [MAXLEN-1:0] pat,
    input  logic [3:0]        len,
    output logic              match
);

    localparam int unsigned FW = $clog2(MAXLEN + 1);

    logic [MAXLEN-1:0] hist_q, hist_d, hist_shift, mask;
    logic [FW-1:0]     fill_q, fill_d, fill_inc;
    int unsigned       len_eff;

    always_comb begin
        len_eff    = (32'(len) > MAXLEN) ? MAXLEN : 32'(len);
        hist_shift = {hist_q[MAXLEN-2:0], w};
        // Fill counts the incoming bit too, saturating at the history depth.
        fill_inc   = (32'(fill_q) >= MAXLEN) ? fill_q : fill_q + FW'(1);
        for (int unsigned i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < len_eff);
        end
        match = accept && (len_eff != 0) && (32'(fill_inc) >= len_eff) &&
                (((hist_shift ^ pat) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_shift;
`ifdef SEQ_DETECT_OVERLAP_EN
            fill_d = fill_inc;
`else
            fill_d = match ? '0 : fill_inc;
`endif
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for the serial sequence detector.
// Ports:
//   clk, Reset     - clock, asynchronous active-low reset
//   start, abort   - begin a run (IDLE only) / terminate a run (RUN only)
//   pat, len, win  - pattern, pattern length, number of bits per run (latched on start)
//   w, w_valid     - serial data bit and its qualifier
//   busy           - high in LOAD and RUN
//   z              - one-cycle match pulse, the cycle after the accepting edge
//   count          - matches in the current or last run (saturating)
//   done           - one-cycle pulse after normal completion
// Build option: SEQ_DETECT_OVERLAP_EN (see seq_match_core) allows overlapping matches.
module seq_detect_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned MAXLEN = MAXLEN_DEFAULT,
    parameter int unsigned CNTW   = CNTW_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] pat,
    input  logic [3:0]        len,
    input  logic [CNTW-1:0]   win,
    input  logic              w,
    input  logic              w_valid,
    output logic              busy,
    output logic              z,
    output logic [CNTW-1:0]   count,
    output logic              done
);

    state_e            state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [3:0]        len_q, len_d;
    logic [CNTW-1:0]   win_q, win_d;
    logic [CNTW-1:0]   remaining_q, remaining_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              z_q, z_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              accept, clear, match;

    // An aborting cycle discards its bit.
    assign accept = (state_q == StRun) && w_valid && !abort;
    assign clear  = (state_q == StLoad);

    seq_match_core #(
        .MAXLEN(MAXLEN)
    ) u_core (
        .clk   (clk),
        .Reset (Reset),
        .clear (clear),
        .accept(accept),
        .w     (w),
        .pat   (pat_q),
        .len   (len_q),
        .match (match)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        win_d       = win_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        z_d         = match;
        done_d      = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d   = pat;
                    len_d   = len;
                    win_d   = win;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d     = '0;
                remaining_d = win_q;
                state_d     = (win_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (w_valid) begin
                    remaining_d = remaining_q - CNTW'(1);
                    if (match && (count_q != '1)) begin
                        count_d = count_q + CNTW'(1);
                    end
                    if (remaining_q == CNTW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StLoad) || (state_d == StRun);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            pat_q       <= '0;
            len_q       <= '0;
            win_q       <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            z_q         <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            win_q       <= win_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            z_q         <= z_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign z     = z_q;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNTW, default 8: width of the window and match counters.
REQ-003 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 Port Reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: begin a detection run; honoured only in IDLE.
REQ-006 Port abort, input, 1: terminate the run; honoured only in RUN.
REQ-007 Port pat, input, MAXLEN: pattern; pat[len-1] is the first bit received, pat[0] the last.
REQ-008 Port len, input, 4: pattern length, valid range 1..MAXLEN.
REQ-009 Port win, input, CNTW: number of serial bits to examine in one run.
REQ-010 Port w, input, 1: serial data bit.
REQ-011 Port w_valid, input, 1: w is accepted on a posedge where w_valid=1 and state=RUN.
REQ-012 Port busy, output, 1: high in LOAD and RUN.
REQ-013 Port z, output, 1: registered one-cycle match pulse.
REQ-014 Port count, output, CNTW: matches counted in the current or last run.
REQ-015 Port done, output, 1: one-cycle pulse at normal run completion.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-017 IDLE with start=1 SHALL latch pat, len and win, then go to LOAD.
REQ-018 LOAD SHALL last one cycle, clear the bit history, the fill counter and count, and load remaining=win.
REQ-019 LOAD SHALL go to RUN if win!=0, and to DONE if win==0.
REQ-020 History SHALL be a MAXLEN shift register; each accepted bit enters h[0].
REQ-021 Each accepted bit SHALL decrement remaining and increment fill; fill saturates at MAXLEN.
REQ-022 A match SHALL occur when the accepted bit completes h[len-1:0]==pat[len-1:0] and fill (including that bit) is >=len.
REQ-023 On a match, z SHALL be 1 for exactly the cycle after the accepting edge; otherwise z=0.
REQ-024 On a match, count SHALL increment on that same edge and saturate at 2^CNTW-1.
REQ-025 The bit that makes remaining reach 0 SHALL still be evaluated for a match, and the FSM SHALL then go to DONE.
REQ-026 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-027 count SHALL hold its value in IDLE until the next LOAD.
REQ-028 Cycles in RUN with w_valid=0 SHALL change nothing.
REQ-029 abort=1 in RUN SHALL go to IDLE on the next edge.
REQ-030 On abort, the same-cycle bit SHALL be discarded, done SHALL NOT pulse, z SHALL be 0, and count SHALL be retained.
REQ-031 A latched len of 0 SHALL yield no matches; a latched len >MAXLEN SHALL be clamped to MAXLEN.
REQ-032 start outside IDLE, and abort outside RUN, SHALL be ignored.

Reset
REQ-033 Reset=0 SHALL immediately force IDLE, z=0, done=0, busy=0, count=0 and clear history, fill and remaining, including mid-run.
REQ-034 The first start is honoured on the first posedge after Reset rises.

Configuration
REQ-035 With SEQ_DETECT_OVERLAP_EN defined, fill SHALL be unaffected by a match, so matches may overlap (for 101, stream 10101 gives 2 matches).
REQ-036 Without SEQ_DETECT_OVERLAP_EN, fill SHALL clear to 0 on a match, so the next match needs len fresh bits (for 101, stream 10101 gives 1 match).

Structure
REQ-037 Package seq_pkg SHALL hold the FSM state encoding (IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11) and the default MAXLEN/CNTW constants.
REQ-038 Sub-module seq_match_core SHALL contain the history register, the fill counter and the match compare.
REQ-039 seq_match_core SHALL have inputs clear, accept, w, pat and len, and a combinational match output.
REQ-040 seq_detect_ctrl SHALL own the FSM, remaining, count, z, done and busy.

Verification
REQ-041 pat=3'b101, len=3, win=5, stream 1,0,1,0,1 with w_valid=1 -> overlap build: z pulses after bits 3 and 5, count=2, done one cycle after the last z; non-overlap build: count=1.
REQ-042 win=0 with start -> LOAD, then DONE, then IDLE; done pulses exactly once, count=0, z never asserted.
REQ-043 pat=101, len=3, win=6, w_valid low every other cycle -> result identical to continuous w_valid; done is delayed only by the idle cycles.
REQ-044 Abort after 2 matches, mid-stream -> busy falls next edge, count=2 retained, no done; start pulses during RUN are ignored.
REQ-045 Reset low mid-RUN with count=3 -> asynchronously count=0, z=0, busy=0, state IDLE; a new run afterwards behaves per REQ-041.
REQ-046 len=15, pat all-ones, 20 ones, win=20 -> treated as len=MAXLEN=8; overlap build: count=13; non-overlap build: count=2.
